// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
//
// Round-robin front end that shares a single GCD core among N requesters.
// The arbiter picks a requester, latches its operands and starts the core.
// It then waits for the core's done flag, guarded by a watchdog, and returns
// the result with a one-cycle acknowledge.
//
// Operand pairs in which either value is zero never reach the core. Their
// result is known to be op_a | op_b, so the arbiter answers them directly.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   req         [N]    request level per requester, held until its ack
//   op_a, op_b  [N*W]  operands, requester i at [i*W +: W]
//   ack         [N]    one-cycle acknowledge to the served requester
//   result      [W]    GCD result, valid while an ack bit is high
//   err         1      high with ack when the job was aborted by the watchdog
//   busy        1      high in every state except IDLE
//   gcd_start   1      one-cycle start pulse to the core
//   gcd_a/gcd_b [W]    operands to the core, held from latch through RESP
//   gcd_done    1      core done flag
//   gcd_result  [W]    core result, valid with gcd_done
//   gcd_abort   1      one-cycle pulse forcing the core back to idle
// -----------------------------------------------------------------------------
module gcd_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   result,
    output logic           err,
    output logic           busy,
    output logic           gcd_start,
    output logic [W-1:0]   gcd_a,
    output logic [W-1:0]   gcd_b,
    input  logic           gcd_done,
    input  logic [W-1:0]   gcd_result,
    output logic           gcd_abort
);

    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [SEL_W-1:0]   last_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [N-1:0]       ack_reg, ack_next;
    logic [W-1:0]       result_reg, result_next;
    logic               err_reg, err_next;
    logic               busy_reg, busy_next;
    logic               start_reg, start_next;
    logic [W-1:0]       gcd_a_reg, gcd_b_reg;
    logic               resp_next;

    logic [W-1:0]       op_a_arr [N];
    logic [W-1:0]       op_b_arr [N];
    logic [W-1:0]       grant_a, grant_b;
    logic               grant_valid;
    logic [SEL_W-1:0]   grant_idx;
    logic               bypass;
    logic               timeout_hit;
    int                 cand_idx;

    // Unpack the flat operand buses into per-requester words.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign op_a_arr[gi] = op_a[gi*W +: W];
            assign op_b_arr[gi] = op_b[gi*W +: W];
        end
    endgenerate

    // Round-robin search: the first set request starting one past the last
    // served requester, wrapping at N. The sum last+k never exceeds 2N-1,
    // so a single conditional subtract replaces a modulo.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = 0;
        for (int k = 1; k <= N; k++) begin
            cand_idx = int'(last_reg) + k;
            if (cand_idx >= N) begin
                cand_idx = cand_idx - N;
            end
            if (!grant_valid && req[cand_idx[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[SEL_W-1:0];
            end
        end
    end

    assign grant_a     = op_a_arr[grant_idx];
    assign grant_b     = op_b_arr[grant_idx];
    assign bypass      = (grant_a == '0) || (grant_b == '0);
    assign timeout_hit = (cnt_reg == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_valid) begin
                    state_next = bypass ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (gcd_done || timeout_hit) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: the values the output registers take on the next edge,
    // so that every handshake output leaves a flop.
    always_comb begin
        sel_next    = sel_reg;
        start_next  = 1'b0;
        busy_next   = (state_next != S_IDLE);
        resp_next   = 1'b0;
        result_next = '0;
        err_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (grant_valid) begin
                    sel_next = grant_idx;
                    if (bypass) begin
                        resp_next   = 1'b1;
                        result_next = grant_a | grant_b;
                    end else begin
                        start_next = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // A done flag that arrives on the last watchdog cycle still wins.
                if (gcd_done) begin
                    resp_next   = 1'b1;
                    result_next = gcd_result;
                end else if (timeout_hit) begin
                    resp_next = 1'b1;
                    err_next  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ack
            assign ack_next[gi] = resp_next && (sel_next == SEL_W'(gi));
        end
    endgenerate

    // The abort is decoded from the registered state and counter. It is gated
    // by gcd_done, so that a result arriving on the final watchdog cycle
    // does not also kill the core.
    assign gcd_abort = (state_reg == S_WAIT) && timeout_hit && !gcd_done;

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_reg    <= '0;
            last_reg   <= LAST_RST;
            cnt_reg    <= '0;
            ack_reg    <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            start_reg  <= 1'b0;
            gcd_a_reg  <= '0;
            gcd_b_reg  <= '0;
        end else begin
            sel_reg    <= sel_next;
            ack_reg    <= ack_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            busy_reg   <= busy_next;
            start_reg  <= start_next;

            if (state_reg == S_IDLE && grant_valid) begin
                gcd_a_reg <= grant_a;
                gcd_b_reg <= grant_b;
            end

            if (state_reg == S_ISSUE) begin
                cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            if (state_reg == S_RESP) begin
                last_reg <= sel_reg;
            end
        end
    end

    assign ack       = ack_reg;
    assign result    = result_reg;
    assign err       = err_reg;
    assign busy      = busy_reg;
    assign gcd_start = start_reg;
    assign gcd_a     = gcd_a_reg;
    assign gcd_b     = gcd_b_reg;

endmodule

// File: tb/tb_gcd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gcd_arbiter
//
// Directed bench for gcd_arbiter (N=4, W=8, TIMEOUT=16). A behavioural core
// stub raises gcd_done a programmable number of cycles after gcd_start. The
// stub returns a programmed result. A latency of 0 means the stub never
// finishes.
// Cycle numbering: cycle 0 is the IDLE cycle that samples the request.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gcd_arbiter;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] op_a = '0;
    logic [N*W-1:0] op_b = '0;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           err;
    logic           busy;
    logic           gcd_start;
    logic [W-1:0]   gcd_a;
    logic [W-1:0]   gcd_b;
    logic           gcd_done = 1'b0;
    logic [W-1:0]   gcd_result = '0;
    logic           gcd_abort;

    int checks = 0;
    int errors = 0;

    // core stub configuration and state
    int           model_lat = 0;
    logic [W-1:0] model_res = '0;
    int           rem = 0;
    logic         running = 1'b0;

    // results of the most recent wait_ack
    int           got_cyc, n_start, n_abort, start_cyc, abort_cyc;
    logic [N-1:0] got_ack;
    logic [W-1:0] got_res, a_at_start, b_at_start;
    logic         got_err;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .gcd_start  (gcd_start),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .gcd_abort  (gcd_abort)
    );

    always #5 clk = ~clk;

    // Core stub: when start is seen at edge t, done is high in the cycle
    // that begins at edge t + model_lat.
    always @(posedge clk) begin
        if (reset || gcd_abort) begin
            running  <= 1'b0;
            gcd_done <= 1'b0;
        end else if (gcd_start) begin
            running  <= (model_lat != 0);
            rem      <= model_lat;
            gcd_done <= 1'b0;
        end else if (running) begin
            if (rem == 1) begin
                gcd_done   <= 1'b1;
                gcd_result <= model_res;
                running    <= 1'b0;
            end else begin
                rem      <= rem - 1;
                gcd_done <= 1'b0;
            end
        end else begin
            gcd_done <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = 99;
        for (int i = 0; i < N; i++) begin
            if (v == (N'(1) << i)) r = i;
        end
        return r;
    endfunction

    task automatic start_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req[idx]           = 1'b1;
        op_a[idx*W +: W]   = a;
        op_b[idx*W +: W]   = b;
    endtask

    // Called in cycle 0. Waits up to max_cyc falling edges for an ack, and
    // records start/abort activity on the way. The served request is
    // dropped at the edge where ack is seen.
    task automatic wait_ack(input int max_cyc, input string name);
        got_cyc = 0; n_start = 0; n_abort = 0; start_cyc = 0; abort_cyc = 0;
        got_ack = '0; got_res = '0; got_err = 1'b0;
        a_at_start = '0; b_at_start = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (gcd_start) begin
                n_start++;
                start_cyc  = c;
                a_at_start = gcd_a;
                b_at_start = gcd_b;
            end
            if (gcd_abort) begin
                n_abort++;
                abort_cyc = c;
            end
            if (ack != '0) begin
                got_cyc = c;
                got_ack = ack;
                got_res = result;
                got_err = err;
                req     = req & ~ack;
                $display("txn %s ack=%b result=%0d err=%0d cycle=%0d", name, ack, result, err, c);
                break;
            end
        end
        check_eq({name, "_ack_seen"}, 32'(got_cyc != 0), 1);
    endtask

    // One cycle after RESP: must be IDLE with busy low. It also serves as
    // cycle 0 for the next request.
    task automatic idle_gap(input string name);
        @(negedge clk);
        check_eq({name, "_gap_busy"}, 32'(busy), 0);
        check_eq({name, "_gap_ack"}, 32'(ack), 0);
    endtask

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        // ---- reset values
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_ack", 32'(ack), 0);
        check_eq("rst_result", 32'(result), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_start", 32'(gcd_start), 0);
        check_eq("rst_abort", 32'(gcd_abort), 0);
        check_eq("rst_gcd_a", 32'(gcd_a), 0);
        check_eq("rst_gcd_b", 32'(gcd_b), 0);
        reset = 1'b0;
        @(negedge clk);

        // ---- single job: 48,18 -> 6, done 4 cycles after start
        model_lat = 4; model_res = 8'd6;
        start_req(0, 8'd48, 8'd18);
        wait_ack(20, "single");
        check_eq("single_cycle", 32'(got_cyc), 7);
        check_eq("single_ack", 32'(got_ack), 32'b0001);
        check_eq("single_result", 32'(got_res), 6);
        check_eq("single_err", 32'(got_err), 0);
        check_eq("single_nstart", 32'(n_start), 1);
        check_eq("single_start_cyc", 32'(start_cyc), 1);
        check_eq("single_gcd_a", 32'(a_at_start), 48);
        check_eq("single_gcd_b", 32'(b_at_start), 18);
        check_eq("single_nabort", 32'(n_abort), 0);
        idle_gap("single");

        // ---- round-robin from reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_lat = 2; model_res = 8'd4;
        for (int i = 0; i < N; i++) start_req(i, 8'd12, 8'd8);
        for (int n = 0; n < 5; n++) begin
            wait_ack(30, "rr");
            check_eq($sformatf("rr_order%0d", n), 32'(onehot_idx(got_ack)), 32'(exp_order[n]));
            check_eq($sformatf("rr_result%0d", n), 32'(got_res), 4);
            check_eq($sformatf("rr_err%0d", n), 32'(got_err), 0);
            if (n == 3) start_req(0, 8'd12, 8'd8);
            idle_gap("rr");
        end

        // ---- bypass: 0,35 -> 35 with no core start
        start_req(2, 8'd0, 8'd35);
        wait_ack(5, "bypass");
        check_eq("bypass_cycle", 32'(got_cyc), 1);
        check_eq("bypass_ack", 32'(got_ack), 32'b0100);
        check_eq("bypass_result", 32'(got_res), 35);
        check_eq("bypass_err", 32'(got_err), 0);
        check_eq("bypass_nstart", 32'(n_start), 0);
        idle_gap("bypass");

        // ---- bypass: 0,0 -> 0
        start_req(1, 8'd0, 8'd0);
        wait_ack(5, "zero");
        check_eq("zero_cycle", 32'(got_cyc), 1);
        check_eq("zero_ack", 32'(got_ack), 32'b0010);
        check_eq("zero_result", 32'(got_res), 0);
        check_eq("zero_err", 32'(got_err), 0);
        check_eq("zero_nstart", 32'(n_start), 0);
        idle_gap("zero");

        // ---- timeout: core never finishes
        model_lat = 0;
        start_req(3, 8'd10, 8'd4);
        wait_ack(40, "timeout");
        check_eq("timeout_nabort", 32'(n_abort), 1);
        check_eq("timeout_abort_cyc", 32'(abort_cyc), 17);
        check_eq("timeout_cycle", 32'(got_cyc), 18);
        check_eq("timeout_ack", 32'(got_ack), 32'b1000);
        check_eq("timeout_result", 32'(got_res), 0);
        check_eq("timeout_err", 32'(got_err), 1);
        idle_gap("timeout");

        // ---- the next job after a timeout is served normally
        model_lat = 2; model_res = 8'd4;
        start_req(0, 8'd12, 8'd8);
        wait_ack(20, "post_to");
        check_eq("post_to_cycle", 32'(got_cyc), 5);
        check_eq("post_to_ack", 32'(got_ack), 32'b0001);
        check_eq("post_to_result", 32'(got_res), 4);
        check_eq("post_to_err", 32'(got_err), 0);
        check_eq("post_to_nabort", 32'(n_abort), 0);
        idle_gap("post_to");

        // ---- done on the last watchdog cycle wins over abort
        model_lat = 15; model_res = 8'd9;
        start_req(1, 8'd27, 8'd18);
        wait_ack(40, "coincide");
        check_eq("coincide_nabort", 32'(n_abort), 0);
        check_eq("coincide_cycle", 32'(got_cyc), 18);
        check_eq("coincide_ack", 32'(got_ack), 32'b0010);
        check_eq("coincide_result", 32'(got_res), 9);
        check_eq("coincide_err", 32'(got_err), 0);
        idle_gap("coincide");

        // ---- reset in the middle of WAIT
        model_lat = 0;
        start_req(2, 8'd20, 8'd6);
        repeat (4) @(negedge clk);
        check_eq("midrst_busy_before", 32'(busy), 1);
        reset  = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        check_eq("midrst_ack", 32'(ack), 0);
        check_eq("midrst_result", 32'(result), 0);
        check_eq("midrst_err", 32'(err), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_start", 32'(gcd_start), 0);
        check_eq("midrst_abort", 32'(gcd_abort), 0);
        check_eq("midrst_gcd_a", 32'(gcd_a), 0);
        check_eq("midrst_gcd_b", 32'(gcd_b), 0);
        reset = 1'b0;
        model_lat = 2; model_res = 8'd5;
        start_req(1, 8'd15, 8'd10);
        start_req(3, 8'd15, 8'd10);
        wait_ack(20, "after_rst1");
        check_eq("after_rst1_ack", 32'(got_ack), 32'b0010);
        check_eq("after_rst1_cycle", 32'(got_cyc), 5);
        check_eq("after_rst1_result", 32'(got_res), 5);
        idle_gap("after_rst1");
        wait_ack(20, "after_rst2");
        check_eq("after_rst2_ack", 32'(got_ack), 32'b1000);
        check_eq("after_rst2_result", 32'(got_res), 5);
        idle_gap("after_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=expired expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
